mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the MIPS instruction-fetch port (I, read-only) and the load/store data port (D).
- Fixed priority D > I, with a starvation guard so fetch is never blocked indefinitely.
- Request/ready handshake per port, with a bus-error timeout when memory fails to acknowledge.
- Sits between the processor core and the memory model; the core stalls on the port whose ready has not yet pulsed.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and load/store (D).
// Fixed D > I priority with a starvation guard and an ack timeout. Optional MEM_ARB_PERF_EN adds perf counters.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          bus_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_cnt,
  output logic [31:0]   perf_d_cnt,
  output logic [31:0]   perf_conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          own_d_q, own_d_d;
  logic [3:0]    starve_q, starve_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_i;

  always_comb begin
    state_d   = state_q;
    own_d_d   = own_d_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    en_d      = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_i   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_i = i_req && (!d_req || starve_q == STARVE_MAX);
          own_d_d = !grant_i;
          en_d    = 1'b1;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
          if (grant_i) begin
            starve_d = '0;
            addr_d   = i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
          end else begin
            // I only accrues starvation when it actually lost to D
            if (i_req && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = RESP;
          if (own_d_q) d_rdata_d = we_q ? '0 : mem_rdata;
          else         i_rdata_d = mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (own_d_q) d_rdata_d = '0;
          else         i_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      own_d_q   <= 1'b0;
      starve_q  <= '0;
      tmo_q     <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_d_q   <= own_d_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ready   = (state_q == RESP) && !own_d_q;
  assign d_ready   = (state_q == RESP) && own_d_q;
  assign bus_err   = (state_q == RESP) && err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_i_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_c_q, perf_c_d;

  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    perf_c_d = perf_c_q;
    if (i_ready) perf_i_d = perf_i_q + 32'd1;
    if (d_ready) perf_d_d = perf_d_q + 32'd1;
    if (state_q == IDLE && i_req && d_req) perf_c_d = perf_c_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_i_cnt        = perf_i_q;
  assign perf_d_cnt        = perf_d_q;
  assign perf_conflict_cnt = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: responses and memory strobes are queued by the
// stimulus and checked by independent monitors; a small memory model answers mem_en.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_cnt;
  logic [31:0] perf_d_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_LIMIT(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_ready(i_ready),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .bus_err(bus_err),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_cnt(perf_i_cnt),
    .perf_d_cnt(perf_d_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wd;
  } mreq_t;

  rsp_t  exp_q[$];
  mreq_t mem_q[$];

  int total;
  int bad;
  int cyc;
  int n_done;
  int last_ready_cyc;
  int rc;
  int late_req;
  int late_done;
  bit ack_on;

  logic [31:0] mem_model [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: sees mem_en, acks one cycle later; can also inject a stray ack on demand.
  initial begin
    logic [31:0] p_addr;
    logic [31:0] p_wd;
    bit          p_we;
    bit          pend;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    pend      = 1'b0;
    late_done = 0;
    p_addr    = '0;
    p_wd      = '0;
    p_we      = 1'b0;
    mem_model[32'h4]  = 32'h8C01_0000;
    mem_model[32'h8]  = 32'h3333_4444;
    mem_model[32'h20] = 32'h1111_2222;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (pend) begin
        mem_ack = 1'b1;
        pend    = 1'b0;
        if (p_we) begin
          mem_model[p_addr] = p_wd;
          mem_rdata = 32'hDEAD_BEEF;
        end else begin
          mem_rdata = mem_model.exists(p_addr) ? mem_model[p_addr] : '0;
        end
      end else if (late_req != late_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        late_done++;
      end else if (mem_en && ack_on) begin
        pend   = 1'b1;
        p_addr = mem_addr;
        p_we   = mem_we;
        p_wd   = mem_wdata;
      end
    end
  end

  // Response and memory-strobe monitors.
  initial begin
    rsp_t  e;
    mreq_t m;
    logic [33:0] act;
    logic [33:0] want;
    logic [64:0] mact;
    logic [64:0] mwant;
    forever begin
      @(negedge clk);
      if (i_ready && d_ready) begin
        total++;
        bad++;
        $display("FAIL both_ready: got i_ready=%0b d_ready=%0b want only one", i_ready, d_ready);
      end
      if (i_ready || d_ready) begin
        total++;
        n_done++;
        last_ready_cyc = cyc;
        act = {d_ready, (d_ready ? d_rdata : i_rdata), bus_err};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready: got port_d/rdata/err=%h want no response", act);
        end else begin
          e = exp_q.pop_front();
          want = {e.port_d, e.rdata, e.err};
          if (act !== want) begin
            bad++;
            $display("FAIL response: got port_d/rdata/err=%h want %h", act, want);
          end
        end
      end
      if (mem_en) begin
        total++;
        mact = {mem_addr, mem_we, mem_wdata};
        if (mem_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_mem_en: got addr/we/wdata=%h want no strobe", mact);
        end else begin
          m = mem_q.pop_front();
          mwant = {m.addr, m.we, m.wd};
          if (mact !== mwant) begin
            bad++;
            $display("FAIL mem_strobe: got addr/we/wdata=%h want %h", mact, mwant);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push_rsp(input bit port_d, input logic [31:0] rdata, input bit err);
    rsp_t e;
    e.port_d = port_d;
    e.rdata  = rdata;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input logic [31:0] addr, input bit we, input logic [31:0] wd);
    mreq_t m;
    m.addr = addr;
    m.we   = we;
    m.wd   = wd;
    mem_q.push_back(m);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int k = 0; k < budget && n_done < target; k++) begin
      @(posedge clk);
      #2;
    end
    if (n_done < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d completions want %0d", name, n_done, target);
    end
  endtask

  function automatic logic [135:0] all_outs();
    return {3'b0, i_ready, d_ready, bus_err, mem_en, mem_we,
            mem_addr, mem_wdata, i_rdata, d_rdata};
  endfunction

  initial begin
    total = 0; bad = 0; n_done = 0; last_ready_cyc = 0; late_req = 0; ack_on = 1'b1;
    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", all_outs(), '0);
    reset = 1'b1;
    @(posedge clk);
    #2;

    // Fetch only, 3-cycle latency
    push_rsp(1'b0, 32'h8C01_0000, 1'b0);
    push_mem(32'h4, 1'b0, 32'h0);
    i_addr = 32'h4; i_req = 1'b1; rc = cyc;
    wait_done(1, 20, "fetch");
    i_req = 1'b0;
    chk("fetch_latency", 136'(last_ready_cyc - rc), 136'd3);

    // Store
    push_rsp(1'b1, 32'h0, 1'b0);
    push_mem(32'h10, 1'b1, 32'hAA);
    d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAA; d_req = 1'b1;
    wait_done(2, 20, "store");
    d_req = 1'b0;

    // Timeout: no ack for the whole BUSY window
    ack_on = 1'b0;
    push_rsp(1'b1, 32'h0, 1'b1);
    push_mem(32'h30, 1'b0, 32'h0);
    d_we = 1'b0; d_addr = 32'h30; d_wdata = 32'h0; d_req = 1'b1; rc = cyc;
    wait_done(3, 40, "timeout");
    d_req = 1'b0;
    chk("timeout_latency", 136'(last_ready_cyc - rc), 136'd17);
    ack_on = 1'b1;
    late_req++;
    repeat (4) @(posedge clk);
    #2;
    chk("late_ack_ignored", 136'(n_done), 136'd3);

    // Normal load after timeout reads back the earlier store
    push_rsp(1'b1, 32'hAA, 1'b0);
    push_mem(32'h10, 1'b0, 32'h0);
    d_addr = 32'h10; d_req = 1'b1;
    wait_done(4, 20, "load_after_timeout");
    d_req = 1'b0;
    chk("i_rdata_hold", 136'(i_rdata), 136'h8C01_0000);

    // Continuous conflict: D,D,D,D,I,D,D,D,D,I
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) begin
        push_rsp(1'b0, 32'h3333_4444, 1'b0);
        push_mem(32'h8, 1'b0, 32'h0);
      end else begin
        push_rsp(1'b1, 32'h1111_2222, 1'b0);
        push_mem(32'h20, 1'b0, 32'h77);
      end
    end
    i_addr = 32'h8; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h77;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(14, 80, "conflict");
    i_req = 1'b0; d_req = 1'b0;

    // Reset during BUSY
    i_addr = 32'h4; i_req = 1'b1;
    for (int k = 0; k < 6 && !mem_en; k++) begin
      @(posedge clk);
      #2;
    end
    chk("mid_reset_in_busy", 136'(mem_en), 136'd1);
    if (mem_en) void'(mem_q.size());
    reset = 1'b0; i_req = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), '0);
    #5;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("post_reset_no_ready", 136'(n_done), 136'd14);
    chk("post_reset_i_rdata", 136'(i_rdata), 136'd0);

    // Perf sequence: 3 fetches, 2 stores, 1 conflict cycle
    push_rsp(1'b0, 32'h8C01_0000, 1'b0);
    push_mem(32'h4, 1'b0, 32'h0);
    i_addr = 32'h4; i_req = 1'b1;
    wait_done(15, 20, "perf_fetch1");
    i_req = 1'b0;

    push_rsp(1'b1, 32'h0, 1'b0);
    push_mem(32'h44, 1'b1, 32'h55);
    d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55; d_req = 1'b1;
    wait_done(16, 20, "perf_store1");
    d_req = 1'b0;

    push_rsp(1'b1, 32'h0, 1'b0);
    push_mem(32'h48, 1'b1, 32'h66);
    push_rsp(1'b0, 32'h3333_4444, 1'b0);
    push_mem(32'h8, 1'b0, 32'h0);
    d_addr = 32'h48; d_wdata = 32'h66; i_addr = 32'h8;
    d_req = 1'b1; i_req = 1'b1;
    wait_done(17, 20, "perf_conflict_d");
    d_req = 1'b0;
    wait_done(18, 20, "perf_conflict_i");
    i_req = 1'b0;

    push_rsp(1'b0, 32'h1111_2222, 1'b0);
    push_mem(32'h20, 1'b0, 32'h0);
    i_addr = 32'h20; i_req = 1'b1;
    wait_done(19, 20, "perf_fetch3");
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;

`ifdef MEM_ARB_PERF_EN
    chk("perf_i_cnt", 136'(perf_i_cnt), 136'd3);
    chk("perf_d_cnt", 136'(perf_d_cnt), 136'd2);
    chk("perf_conflict_cnt", 136'(perf_conflict_cnt), 136'd1);
`endif

    chk("rsp_queue_drained", 136'(exp_q.size()), 136'd0);
    chk("mem_queue_drained", 136'(mem_q.size()), 136'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
